// File: rtl/layer7_weight_reader.sv
`default_nettype none
// ============================================================================
//  Module   : layer7_weight_reader
//  Purpose  : Read-side sequencer for the layer-7 local weight memory. Walks
//             line indices 0..LINES-1, drives the two-bank read port, captures
//             each 128-bit line pair one cycle later and streams the pairs to
//             the PE array through a 2-entry valid/ready output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module layer7_weight_reader #(
    parameter int LINES  = 25,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              read_weight_signal,
    output logic [ADDR_W-1:0] read_weight_addr1,
    output logic [ADDR_W-1:0] read_weight_addr2,
    input  logic [127:0]      read_weight_data1,
    input  logic [127:0]      read_weight_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_weight1,
    output logic [127:0]      out_weight2,
    output logic [5:0]        out_index
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int         CNT_W    = 7;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] req_cnt_q;
    logic             in_flight_q;
    logic [5:0]       cap_idx_q;

    logic [127:0]     fifo_w1_q  [2];
    logic [127:0]     fifo_w2_q  [2];
    logic [5:0]       fifo_idx_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    logic             w_pop;
    logic             w_push;
    logic [2:0]       w_occ;
    logic             w_issue;
    logic             w_last_issue;
    logic             w_drained;
    logic [5:0]       w_addr_idx;

    // Credit is judged on the occupancy left after this cycle's pop, so a
    // continuously-ready consumer sees one pair per cycle while the buffer
    // plus the in-flight read never exceed two entries.
    assign w_pop        = (count_q != 2'd0) & out_ready;
    assign w_push       = in_flight_q;
    assign w_occ        = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, w_pop};
    assign w_issue      = (state_q == S_RUN) && (w_occ < 3'd2);
    assign w_last_issue = w_issue && (req_cnt_q == LAST_IDX);
    assign w_drained    = !in_flight_q &&
                          ((count_q == 2'd0) || ((count_q == 2'd1) && w_pop));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)        state_d = S_RUN;
            S_RUN:   if (w_last_issue) state_d = S_DRAIN;
            S_DRAIN: if (w_drained)    state_d = S_FIN;
            S_FIN:                     state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Outputs: the read enable stays up through the capture cycle because the
    // memory gates its data combinationally with it
    always_comb begin
        busy               = (state_q != S_IDLE);
        done               = (state_q == S_FIN);
        read_weight_signal = w_issue | in_flight_q;
        w_addr_idx         = 6'd0;
        if (w_issue) begin
            w_addr_idx = req_cnt_q[5:0];
        end else if (in_flight_q) begin
            w_addr_idx = cap_idx_q;
        end
        read_weight_addr1  = ADDR_W'(w_addr_idx);
        read_weight_addr2  = ADDR_W'(w_addr_idx);
    end

    // Request counter, in-flight flag and index of the outstanding read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt_q   <= '0;
            in_flight_q <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                req_cnt_q <= '0;
            end else if (w_issue) begin
                req_cnt_q <= req_cnt_q + 7'd1;
            end
            in_flight_q <= w_issue;
            if (w_issue) begin
                cap_idx_q <= req_cnt_q[5:0];
            end
        end
    end

    // Two-entry output buffer; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_w1_q[i]  <= '0;
                fifo_w2_q[i]  <= '0;
                fifo_idx_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                fifo_w1_q[wr_ptr_q]  <= read_weight_data1;
                fifo_w2_q[wr_ptr_q]  <= read_weight_data2;
                fifo_idx_q[wr_ptr_q] <= cap_idx_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid   = (count_q != 2'd0);
    assign out_weight1 = fifo_w1_q[rd_ptr_q];
    assign out_weight2 = fifo_w2_q[rd_ptr_q];
    assign out_index   = fifo_idx_q[rd_ptr_q];

endmodule
`default_nettype wire
